// File: rtl/regs_trace_monitor_pkg.sv
// Shared defines for the register trace monitor: register index width,
// the hard-wired x0 index, default watched registers and a width helper.
package regs_trace_monitor_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  localparam int DEF_NUM_CH = 3;
  // Channel 0 watches x27, channel 1 x28, channel 2 x29.
  localparam logic [DEF_NUM_CH*REG_IDX_W-1:0] DEF_CH_IDX = {5'd29, 5'd28, 5'd27};

  // Width of an index over n items, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regs_trace_monitor_fifo.sv
// Show-ahead FIFO for trace entries. When empty, the read port keeps
// presenting the last entry popped (zero after reset).
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [W-1:0]     last_q;
  logic             full, do_pop, do_push;

  assign valid_o = (level_q != '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  // Flush wins over everything; a pop frees a slot for a same-cycle push.
  assign do_pop  = valid_o && pop_i && !clr_i;
  assign do_push = push_i && !clr_i && (!full || do_pop);
  assign drop_o  = push_i && !clr_i && full && !do_pop;

  assign rdata_o = valid_o ? mem[rd_ptr_q] : last_q;
  assign level_o = level_q;

  // Storage write; contents are only observed through the level gate.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

  // Pointers, occupancy and the held last-popped entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        last_q   <= mem[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/regs_trace_monitor.sv
// Snoops register-file writes, logs writes to watched registers with a
// cycle stamp into a FIFO, optionally only when the value changes.
module regs_trace_monitor
  import regs_trace_monitor_pkg::*;
#(
  parameter int                       DATA_W      = 32,
  parameter int                       ADDR_W      = REG_IDX_W,
  parameter int                       NUM_CH      = DEF_NUM_CH,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_IDX      = DEF_CH_IDX,
  parameter int                       DEPTH       = 8,
  parameter int                       STAMP_W     = 16,
  parameter bit                       CHANGE_ONLY = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  input  logic                      trace_en_i,
  input  logic                      clr_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [idx_w(NUM_CH)-1:0]  out_ch_o,
  output logic [DATA_W-1:0]         out_data_o,
  output logic [STAMP_W-1:0]        out_stamp_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic [7:0]                ovf_cnt_o
);

  localparam int CH_W  = idx_w(NUM_CH);
  localparam int ENT_W = CH_W + DATA_W + STAMP_W;

  logic [STAMP_W-1:0]             stamp_q;
  logic [NUM_CH-1:0]              hit, sel, chg;
  logic [NUM_CH-1:0][DATA_W-1:0]  shadow_q;
  logic [NUM_CH-1:0]              shv_q;
  logic [CH_W-1:0]                win;
  logic                           push, drop;
  logic [7:0]                     ovf_q;
  logic [ENT_W-1:0]               rdata;

  // Per-channel match and "value differs from shadow" flags.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign hit[k] = wr_en_i && (wr_addr_i != ADDR_W'(REG_X0)) &&
                    (wr_addr_i == CH_IDX[k*ADDR_W +: ADDR_W]);
    assign chg[k] = !shv_q[k] || (wr_data_i != shadow_q[k]);

    // Shadow tracks every winning match, independent of logging state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadow_q[k] <= '0;
        shv_q[k]    <= 1'b0;
      end else begin
        if (sel[k]) shadow_q[k] <= wr_data_i;
        if (clr_i)       shv_q[k] <= 1'b0;
        else if (sel[k]) shv_q[k] <= 1'b1;
      end
    end
  end

  // Isolate the lowest matching channel.
  assign sel = hit & (~hit + NUM_CH'(1));

  // Encode the one-hot winner into a channel number.
  always_comb begin
    win = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (sel[k]) win = CH_W'(k);
  end

  assign push = (|sel) && trace_en_i && (!CHANGE_ONLY || (|(sel & chg)));

  // Free-running stamp; not affected by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stamp_q <= '0;
    else      stamp_q <= stamp_q + STAMP_W'(1);
  end

  // Dropped-entry counter, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      ovf_q <= '0;
    else if (clr_i)                ovf_q <= '0;
    else if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
  end

  trace_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr_i),
    .push_i  (push),
    .wdata_i ({win, wr_data_i, stamp_q}),
    .pop_i   (out_ready_i),
    .valid_o (out_valid_o),
    .rdata_o (rdata),
    .level_o (level_o),
    .drop_o  (drop)
  );

  assign {out_ch_o, out_data_o, out_stamp_o} = rdata;
  assign ovf_cnt_o = ovf_q;

endmodule

// File: tb/tb_regs_trace_monitor.sv
// Bench: two monitors (CHANGE_ONLY 0 and 1) share stimulus; a queue-based
// model per instance is compared against both on every falling edge.
module tb_regs_trace_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        trace_en = 1'b0;
  logic        clr = 1'b0;
  logic        ready = 1'b0;

  logic [1:0]        vo;
  logic [1:0][1:0]   och;
  logic [1:0][31:0]  od;
  logic [1:0][15:0]  os;
  logic [1:0][3:0]   lvl;
  logic [1:0][7:0]   ovf;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regs_trace_monitor #(.CHANGE_ONLY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .trace_en_i(trace_en), .clr_i(clr), .out_valid_o(vo[0]), .out_ready_i(ready),
    .out_ch_o(och[0]), .out_data_o(od[0]), .out_stamp_o(os[0]), .level_o(lvl[0]),
    .ovf_cnt_o(ovf[0]));

  regs_trace_monitor #(.CHANGE_ONLY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .trace_en_i(trace_en), .clr_i(clr), .out_valid_o(vo[1]), .out_ready_i(ready),
    .out_ch_o(och[1]), .out_data_o(od[1]), .out_stamp_o(os[1]), .level_o(lvl[1]),
    .ovf_cnt_o(ovf[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          ch;
    logic [31:0] d;
    logic [15:0] s;
  } ent_t;

  ent_t        mq [2][$];
  ent_t        mlast [2];
  logic [31:0] msh [2][3];
  bit          msv [2][3];
  int          movf [2];
  int          mstamp;
  int          chx [3] = '{27, 28, 29};

  always @(posedge clk or negedge rst) begin
    int k;
    if (!rst) begin
      mstamp = 0;
      for (int u = 0; u < 2; u++) begin
        mq[u].delete();
        movf[u] = 0;
        mlast[u] = '{0, 32'd0, 16'd0};
        for (int j = 0; j < 3; j++) begin msh[u][j] = '0; msv[u][j] = 0; end
      end
    end else begin
      k = -1;
      if (wr_en && wr_addr != 0)
        for (int j = 2; j >= 0; j--) if (int'(wr_addr) == chx[j]) k = j;
      for (int u = 0; u < 2; u++) begin
        if (clr) begin
          mq[u].delete();
          movf[u] = 0;
          for (int j = 0; j < 3; j++) msv[u][j] = 0;
        end else begin
          int  pre;
          bit  pop, push;
          pre  = mq[u].size();
          pop  = (pre > 0) && ready;
          push = (k >= 0) && trace_en &&
                 (u == 0 || !msv[u][k] || wr_data != msh[u][k]);
          if (pop) mlast[u] = mq[u].pop_front();
          if (push) begin
            if (pre == 8 && !pop) begin
              if (movf[u] < 255) movf[u]++;
            end else mq[u].push_back('{k, wr_data, 16'(mstamp)});
          end
          if (k >= 0) begin msh[u][k] = wr_data; msv[u][k] = 1; end
        end
      end
      mstamp = (mstamp + 1) % 65536;
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      ent_t e;
      int   sz;
      sz = mq[u].size();
      e  = (sz > 0) ? mq[u][0] : mlast[u];
      chk($sformatf("dut%0d valid", u), 32'(vo[u]), 32'(sz > 0));
      chk($sformatf("dut%0d level", u), 32'(lvl[u]), 32'(sz));
      chk($sformatf("dut%0d ovf", u), 32'(ovf[u]), 32'(movf[u]));
      chk($sformatf("dut%0d ch", u), 32'(och[u]), 32'(e.ch));
      chk($sformatf("dut%0d data", u), od[u], e.d);
      chk($sformatf("dut%0d stamp", u), 32'(os[u]), 32'(e.s));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(d);
  endtask

  task automatic idle();
    wr_en = 1'b0;
  endtask

  int          n1;
  logic [31:0] got [2];

  initial begin
    repeat (3) step();
    // Reset state
    chk("rst valid", 32'(vo[0]), 0);
    chk("rst level", 32'(lvl[0]), 0);
    chk("rst ovf", 32'(ovf[0]), 0);
    chk("rst data", od[0], 0);
    chk("rst stamp", 32'(os[0]), 0);

    // Three channels on consecutive cycles, first stamp 0
    rst = 1'b1; trace_en = 1'b1; ready = 1'b1;
    wr(27, 5); step();
    chk("s1 e0 ch", 32'(och[0]), 0); chk("s1 e0 data", od[0], 5); chk("s1 e0 stamp", 32'(os[0]), 0);
    wr(28, 7); step();
    chk("s1 e1 ch", 32'(och[0]), 1); chk("s1 e1 data", od[0], 7); chk("s1 e1 stamp", 32'(os[0]), 1);
    wr(29, 12); step();
    chk("s1 e2 ch", 32'(och[0]), 2); chk("s1 e2 data", od[0], 12); chk("s1 e2 stamp", 32'(os[0]), 2);
    idle(); step();
    chk("s1 empty valid", 32'(vo[0]), 0); chk("s1 hold data", od[0], 12);

    // Change-only logging
    clr = 1'b1; step(); clr = 1'b0;
    n1 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || i == 1) wr(28, 7);
      else if (i == 2) wr(28, 8);
      else idle();
      step();
      if (vo[1]) begin if (n1 < 2) got[n1] = od[1]; n1++; end
    end
    chk("s2 entries", 32'(n1), 2); chk("s2 first", got[0], 7); chk("s2 second", got[1], 8);

    // trace_en=0 still updates shadow; x0 and x5 never log
    trace_en = 1'b0; wr(28, 9); step();
    chk("s5 off dut0", 32'(vo[0]), 0); chk("s5 off dut1", 32'(vo[1]), 0);
    trace_en = 1'b1; wr(28, 9); step();
    chk("s5 dut1 same", 32'(vo[1]), 0); chk("s5 dut0 logs", od[0], 9);
    wr(0, 3); step();
    chk("s5 x0", 32'(vo[0]), 0);
    wr(5, 3); step();
    chk("s5 x5", 32'(lvl[0]), 0);

    // Overflow with consumer stalled
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin wr(27, 101 + i); step(); end
    idle();
    chk("s3 level", 32'(lvl[0]), 8); chk("s3 ovf", 32'(ovf[0]), 2); chk("s3 head", od[0], 101);

    // Full: push and pop together
    ready = 1'b1; wr(29, 200); step();
    chk("s4 level", 32'(lvl[0]), 8); chk("s4 ovf", 32'(ovf[0]), 2); chk("s4 head", od[0], 102);
    idle(); repeat (10) step();
    chk("s4 drained", 32'(vo[0]), 0); chk("s4 last", od[0], 200);

    // Saturation
    ready = 1'b0;
    for (int i = 0; i < 270; i++) begin wr(28, 1000 + i); step(); end
    chk("sat ovf", 32'(ovf[0]), 255);

    // Flush wins over same-cycle push and pop
    clr = 1'b1; ready = 1'b1; wr(27, 1); step(); clr = 1'b0; idle();
    chk("clr valid", 32'(vo[0]), 0); chk("clr level", 32'(lvl[0]), 0); chk("clr ovf", 32'(ovf[0]), 0);

    // Async reset with entries queued
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin wr(29, 50 + i); step(); end
    idle();
    chk("pre-rst level", 32'(lvl[0]), 4);
    #2 rst = 1'b0; #1;
    chk("rst valid now", 32'(vo[0]), 0); chk("rst level now", 32'(lvl[0]), 0);
    step(); step();
    rst = 1'b1; ready = 1'b1; wr(28, 77); step();
    chk("post-rst stamp", 32'(os[0]), 0); chk("post-rst data", od[0], 77);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      wr_en = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 5))
        0: wr_addr = 5'd0;
        1: wr_addr = 5'd5;
        2: wr_addr = 5'd27;
        3: wr_addr = 5'd28;
        4: wr_addr = 5'd29;
        default: wr_addr = 5'($urandom_range(0, 31));
      endcase
      wr_data  = 32'($urandom_range(0, 3));
      trace_en = ($urandom_range(0, 7) != 0);
      ready    = ($urandom_range(0, 2) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      clr      = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 299) == 0) #2 rst = 1'b0;
      step();
      rst = 1'b1;
    end
    idle(); clr = 1'b0; step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regs_trace_monitor.md
REGS_TRACE_MONITOR -- requirements
Module: regs_trace_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.
- NUM_CH, 3, number of watched channels.
- CH_IDX, {5'd29,5'd28,5'd27}, packed register indices, channel k at bits [k*ADDR_W +: ADDR_W].
- DEPTH, 8, FIFO entries, a power of 2 and at least 2.
- STAMP_W, 16, timestamp width.
- CHANGE_ONLY, 0, when 1 a match is logged only when the value changes.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- wr_en_i, in, 1, register-file write enable (snooped).
- wr_addr_i, in, ADDR_W, write index.
- wr_data_i, in, DATA_W, write data.
- trace_en_i, in, 1, logging enable.
- clr_i, in, 1, synchronous flush.
- out_valid_o, out, 1, entry available.
- out_ready_i, in, 1, consumer accepts.
- out_ch_o, out, clog2(NUM_CH) (minimum 1), channel number.
- out_data_o, out, DATA_W, logged value.
- out_stamp_o, out, STAMP_W, cycle stamp.
- level_o, out, clog2(DEPTH)+1, FIFO occupancy.
- ovf_cnt_o, out, 8, count of dropped entries.

Function
REQ-003 Match SHALL be: wr_en_i=1, wr_addr_i!=0, and wr_addr_i==CH_IDX[k]; when several channels match, the lowest k SHALL win.
REQ-004 Each channel SHALL keep a shadow value and a shadow-valid bit, updated on every match regardless of trace_en_i or FIFO state.
REQ-005 Push SHALL occur when match, trace_en_i=1, and (CHANGE_ONLY=0, or shadow-valid=0, or wr_data_i!=shadow).
REQ-006 A push SHALL write {k, wr_data_i, stamp}, where stamp is the free-running counter value in the write cycle; the counter SHALL wrap modulo 2^STAMP_W and SHALL never stop.
REQ-007 Latency: an entry pushed at edge N SHALL appear on out_valid_o/out_* after edge N; the FIFO SHALL be show-ahead.
REQ-008 Handshake: a pop SHALL occur when out_valid_o and out_ready_i are both 1 at a rising edge; while out_valid_o=1 and out_ready_i=0, out_* SHALL hold stable.
REQ-009 Empty: out_valid_o SHALL be 0, out_ready_i SHALL be ignored, and out_* SHALL hold their last value (0 after reset).
REQ-010 Full and push without pop: the entry SHALL be dropped and ovf_cnt_o SHALL increment, saturating at 255.
REQ-011 Full and push with pop in the same cycle: both SHALL succeed, level_o SHALL remain DEPTH, and no overflow SHALL be counted.
REQ-012 Empty and push with out_ready_i=1: no pop SHALL occur that cycle.
REQ-013 Pointers SHALL wrap modulo DEPTH; level_o SHALL equal pushes minus pops, in the range 0..DEPTH.
REQ-014 clr_i=1 SHALL empty the FIFO, zero ovf_cnt_o, and clear all shadow-valid bits; clr_i SHALL take priority over a same-cycle push or pop; the stamp counter SHALL be unaffected.

Reset
REQ-015 rst=0 SHALL asynchronously clear pointers, level_o, ovf_cnt_o, the stamp counter, shadows, shadow-valid bits, out_valid_o, and out_*.
REQ-016 Reset asserted mid-transfer SHALL discard all entries; the first post-reset stamp SHALL be 0 at the first active edge.

Structure
REQ-017 The following SHALL live in the shared defines file:
- Default CH_IDX.
- Register-index width.
- The x0 constant.
REQ-018 FIFO storage and pointers SHALL be the sub-module trace_fifo, parametrised by width and DEPTH; match, shadow, and stamp logic SHALL stay in the top module.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Defaults; writes x27=5, x28=7, x29=12 on consecutive cycles; out_ready_i=1 -> entries (0,5), (1,7), (2,12) with stamps incrementing by 1.
- CHANGE_ONLY=1; x28=7 written twice, then x28=8 -> exactly 2 entries, (1,7) and (1,8).
- out_ready_i=0; 10 matching writes -> level_o=8, ovf_cnt_o=2, first popped data is write #1.
- Full FIFO; push and pop in the same cycle -> level_o stays 8, ovf_cnt_o unchanged, order preserved.
- A write to x0, or to an unwatched x5 -> no entry; with trace_en_i=0 -> no entry, but the shadow is updated (checked via CHANGE_ONLY).
- rst pulsed low with 4 entries queued -> out_valid_o=0 and level_o=0 immediately; clr_i gives the same result synchronously.
